// File: rtl/ac_seq_pkg.sv
// Shared encodings for the accumulator operation sequencer: op codes, bus
// sources, ALU functions and the sequencer state enumeration.
package ac_seq_pkg;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_CLAC     = 4'd1;
    localparam logic [3:0] OP_INCAC    = 4'd2;
    localparam logic [3:0] OP_LDAC_REG = 4'd3;
    localparam logic [3:0] OP_LDAC_MEM = 4'd4;
    localparam logic [3:0] OP_ADD      = 4'd5;
    localparam logic [3:0] OP_SUB      = 4'd6;
    localparam logic [3:0] OP_AND      = 4'd7;
    localparam logic [3:0] OP_OR       = 4'd8;

    // Register sources occupy bus_sel values 2..15.
    localparam logic [3:0] BUS_NONE = 4'd0;
    localparam logic [3:0] BUS_MEM  = 4'd1;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ALU_WB   = 2'd3
    } seq_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic [2:0] alu_fn(input logic [3:0] op);
        logic [2:0] fn;
        fn = ALU_PASS;
        case (op)
            OP_ADD:  fn = ALU_ADD;
            OP_SUB:  fn = ALU_SUB;
            OP_AND:  fn = ALU_AND;
            OP_OR:   fn = ALU_OR;
            default: fn = ALU_PASS;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/ac_seq_wait_timer.sv
// Loadable down-counter pacing the memory-read wait. count holds the number of
// wait cycles remaining including the current one; expired marks the final one.
module ac_seq_wait_timer
    import ac_seq_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] count,
    output logic [3:0] count_next,
    output logic       expired
);

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = 4'(MEM_LAT);
        end else if (dec && (count != 4'd0)) begin
            count_next = count - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else begin
            count <= count_next;
        end
    end

    assign expired = (count == 4'd1);

endmodule

// File: rtl/ac_op_sequencer.sv
// Expands one accumulator operation at a time into registered, cycle-exact
// accumulator strobes. Handshake: an op is taken on any rising edge where
// op_valid && op_ready; op_ready is high only in IDLE and never during rst.
module ac_op_sequencer
    import ac_seq_pkg::*;
#(
    parameter int N       = 17,
    parameter int MEM_LAT = 2,
    parameter int SELW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [3:0]      op_code,
    input  logic [SELW-1:0] op_src,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [SELW-1:0] bus_sel,
    output logic            mem_rd,
    output logic [2:0]      alu_op,
    output logic            write_en,
    output logic            alu_to_ac,
    output logic            inc_en,
    output logic            clr_en,
    output seq_state_e      dbg_state
);

    seq_state_e      state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [SELW-1:0] src_q, src_d;

    logic            tmr_load, tmr_dec, tmr_expired;
    logic [3:0]      tmr_count, tmr_count_next;

    logic            busy_d, done_d, err_d, mem_rd_d;
    logic            write_en_d, alu_to_ac_d, inc_en_d, clr_en_d;
    logic [SELW-1:0] bus_sel_d;
    logic [2:0]      alu_op_d;

    ac_seq_wait_timer #(
        .MEM_LAT(MEM_LAT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .dec       (tmr_dec),
        .count     (tmr_count),
        .count_next(tmr_count_next),
        .expired   (tmr_expired)
    );

    assign op_ready  = (state_q == ST_IDLE) && !rst;
    assign dbg_state = state_q;

    // Next-state and operation capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && op_ready) begin
                    state_d = ST_EXEC;
                    op_d    = op_code;
                    src_d   = op_src;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_LDAC_MEM) begin
                    state_d  = ST_MEM_WAIT;
                    tmr_load = 1'b1;
                end else if (is_alu_op(op_q)) begin
                    state_d = ST_ALU_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_WAIT: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ALU_WB: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so that every strobe
    // comes straight from a flop in the cycle it belongs to.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_rd_d    = 1'b0;
        write_en_d  = 1'b0;
        alu_to_ac_d = 1'b0;
        inc_en_d    = 1'b0;
        clr_en_d    = 1'b0;
        bus_sel_d   = SELW'(BUS_NONE);
        alu_op_d    = ALU_PASS;
        case (state_d)
            ST_EXEC: begin
                case (op_d)
                    OP_NOP: done_d = 1'b1;
                    OP_CLAC: begin
                        clr_en_d = 1'b1;
                        done_d   = 1'b1;
                    end
                    OP_INCAC: begin
                        inc_en_d = 1'b1;
                        done_d   = 1'b1;
                    end
                    OP_LDAC_REG: begin
                        bus_sel_d  = src_d;
                        write_en_d = 1'b1;
                        done_d     = 1'b1;
                    end
                    OP_LDAC_MEM: begin
                        mem_rd_d  = 1'b1;
                        bus_sel_d = SELW'(BUS_MEM);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        bus_sel_d = src_d;
                        alu_op_d  = alu_fn(op_d);
                    end
                    default: begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                endcase
            end
            ST_MEM_WAIT: begin
                bus_sel_d = SELW'(BUS_MEM);
                if (tmr_count_next == 4'd1) begin
                    write_en_d = 1'b1;
                    done_d     = 1'b1;
                end
            end
            ST_ALU_WB: begin
                bus_sel_d   = src_d;
                alu_op_d    = alu_fn(op_d);
                alu_to_ac_d = 1'b1;
                done_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            src_q     <= SELW'(BUS_NONE);
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            write_en  <= 1'b0;
            alu_to_ac <= 1'b0;
            inc_en    <= 1'b0;
            clr_en    <= 1'b0;
            bus_sel   <= SELW'(BUS_NONE);
            alu_op    <= ALU_PASS;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            mem_rd    <= mem_rd_d;
            write_en  <= write_en_d;
            alu_to_ac <= alu_to_ac_d;
            inc_en    <= inc_en_d;
            clr_en    <= clr_en_d;
            bus_sel   <= bus_sel_d;
            alu_op    <= alu_op_d;
        end
    end

endmodule

// File: tb/tb_ac_op_sequencer.sv
// Bench for ac_op_sequencer: each operation is expanded by a reference model
// into its expected per-cycle output trace and compared cycle by cycle.
module tb_ac_op_sequencer;
    import ac_seq_pkg::*;

    localparam int SELW    = 4;
    localparam int MEM_LAT = 2;

    logic            clk;
    logic            rst;
    logic            op_valid;
    logic            op_ready;
    logic [3:0]      op_code;
    logic [SELW-1:0] op_src;
    logic            busy, done, err, mem_rd;
    logic [SELW-1:0] bus_sel;
    logic [2:0]      alu_op;
    logic            write_en, alu_to_ac, inc_en, clr_en;
    seq_state_e      dbg_state;

    // {busy, done, err, bus_sel[3:0], mem_rd, alu_op[2:0], write_en, alu_to_ac, inc_en, clr_en}
    typedef logic [14:0] vec_t;
    vec_t exp_q[$];

    int n_pass;
    int n_checks;

    ac_op_sequencer #(.N(17), .MEM_LAT(MEM_LAT), .SELW(SELW)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_src   (op_src),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus_sel  (bus_sel),
        .mem_rd   (mem_rd),
        .alu_op   (alu_op),
        .write_en (write_en),
        .alu_to_ac(alu_to_ac),
        .inc_en   (inc_en),
        .clr_en   (clr_en),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic b, input logic d, input logic e,
                                input logic [3:0] bs, input logic mr, input logic [2:0] ao,
                                input logic we, input logic aa, input logic inc, input logic clr);
        return {b, d, e, bs, mr, ao, we, aa, inc, clr};
    endfunction

    function automatic vec_t dut_vec();
        return {busy, done, err, bus_sel, mem_rd, alu_op, write_en, alu_to_ac, inc_en, clr_en};
    endfunction

    // Reference model: expected outputs for each cycle from accept+1 to done.
    task automatic build_trace(input logic [3:0] op, input logic [3:0] src);
        exp_q.delete();
        case (op)
            4'd0: exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            4'd1: exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
            4'd2: exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
            4'd3: exp_q.push_back(mk(1, 1, 0, src, 0, 0, 1, 0, 0, 0));
            4'd4: begin
                exp_q.push_back(mk(1, 0, 0, 4'd1, 1, 0, 0, 0, 0, 0));
                for (int i = 1; i <= MEM_LAT; i++) begin
                    if (i == MEM_LAT) exp_q.push_back(mk(1, 1, 0, 4'd1, 0, 0, 1, 0, 0, 0));
                    else              exp_q.push_back(mk(1, 0, 0, 4'd1, 0, 0, 0, 0, 0, 0));
                end
            end
            4'd5, 4'd6, 4'd7, 4'd8: begin
                exp_q.push_back(mk(1, 0, 0, src, 0, 3'(op - 4'd4), 0, 0, 0, 0));
                exp_q.push_back(mk(1, 1, 0, src, 0, 3'(op - 4'd4), 0, 1, 0, 0));
            end
            default: exp_q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        endcase
    endtask

    // Driver: called at a negedge in IDLE; returns at the negedge of the first
    // IDLE cycle after done. With noisy set, op_valid is toggled while busy.
    task automatic run_op(input logic [3:0] op, input logic [3:0] src, input bit noisy);
        vec_t e;
        vec_t got;
        int   idx;
        n_checks++;
        if (op_ready !== 1'b1) $display("FAIL ready_before op=%0d got=%b want=1", op, op_ready);
        else n_pass++;
        op_valid = 1'b1;
        op_code  = op;
        op_src   = src;
        build_trace(op, src);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = 4'($urandom_range(0, 15));
        op_src   = 4'($urandom_range(0, 15));
        idx = 0;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = dut_vec();
            n_checks++;
            if (got !== e) $display("FAIL trace op=%0d cyc=%0d got=%h want=%h", op, idx, got, e);
            else n_pass++;
            n_checks++;
            if (op_ready !== 1'b0) $display("FAIL ready_busy op=%0d cyc=%0d got=%b want=0", op, idx, op_ready);
            else n_pass++;
            n_checks++;
            if ($countones({write_en, alu_to_ac, inc_en, clr_en}) > 1)
                $display("FAIL one_strobe op=%0d cyc=%0d got=%b want=<=1 hot", op, idx,
                         {write_en, alu_to_ac, inc_en, clr_en});
            else n_pass++;
            if (noisy) begin
                op_valid = 1'($urandom_range(0, 1));
                op_code  = 4'($urandom_range(0, 15));
                op_src   = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            idx++;
        end
        op_valid = 1'b0;
        got = dut_vec();
        n_checks++;
        if (got !== 15'd0) $display("FAIL idle_after op=%0d got=%h want=0000", op, got);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        op_valid = 1'b1;
        op_code  = OP_CLAC;
        op_src   = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut_vec() !== 15'd0) $display("FAIL reset_outputs got=%h want=0000", dut_vec());
        else n_pass++;
        n_checks++;
        if (op_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", op_ready);
        else n_pass++;
        n_checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d want=0", dbg_state);
        else n_pass++;
        rst      = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (op_ready !== 1'b1) $display("FAIL ready_after_reset got=%b want=1", op_ready);
        else n_pass++;
    endtask

    task automatic test_clac();       run_op(OP_CLAC, 4'd0, 1'b0);     endtask
    task automatic test_ldac_mem();   run_op(OP_LDAC_MEM, 4'd7, 1'b0); endtask
    task automatic test_add();        run_op(OP_ADD, 4'd5, 1'b0);      endtask
    task automatic test_illegal();    run_op(4'd12, 4'd3, 1'b0);       endtask
    task automatic test_busy_reject(); run_op(OP_LDAC_MEM, 4'd2, 1'b1); endtask

    task automatic test_back_to_back();
        run_op(OP_INCAC, 4'd0, 1'b0);
        run_op(OP_LDAC_REG, 4'd9, 1'b0);
        run_op(OP_NOP, 4'd0, 1'b0);
        run_op(OP_CLAC, 4'd0, 1'b0);
        run_op(OP_OR, 4'd15, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        end
    endtask

    task automatic test_reset_mid_op();
        op_valid = 1'b1;
        op_code  = OP_LDAC_MEM;
        op_src   = 4'd0;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        n_checks++;
        if (mem_rd !== 1'b1) $display("FAIL midrst_mem_rd got=%b want=1", mem_rd);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus_sel !== 4'd1 || write_en !== 1'b0)
            $display("FAIL midrst_wait bus_sel=%0d write_en=%b want=1/0", bus_sel, write_en);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== 15'd0) $display("FAIL midrst_outputs got=%h want=0000", dut_vec());
        else n_pass++;
        n_checks++;
        if (op_ready !== 1'b0) $display("FAIL midrst_ready got=%b want=0", op_ready);
        else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== 15'd0) $display("FAIL midrst_quiet cyc=%0d got=%h want=0000", c, dut_vec());
            else n_pass++;
            n_checks++;
            if (op_ready !== 1'b1) $display("FAIL midrst_ready_back cyc=%0d got=%b want=1", c, op_ready);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 4'd0;
        op_src   = 4'd0;
        @(negedge clk);
        test_reset();
        test_clac();
        test_ldac_mem();
        test_add();
        test_illegal();
        test_busy_reject();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        test_clac();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
